// File: rtl/ft_cmd_pkg.sv
// Purpose: shared constants for the FT245 command controller (opcodes, register map, error codes, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ft_cmd_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_READ  = 4'h1;
  localparam logic [3:0] OP_WRITE = 4'h2;
  localparam logic [3:0] OP_PULSE = 4'h3;
  localparam logic [3:0] OP_ERR   = 4'hE;  // opcode nibble of every error response

  localparam logic [3:0] ADDR_TOTAL    = 4'd0;
  localparam logic [3:0] ADDR_MISMATCH = 4'd1;
  localparam logic [3:0] ADDR_STATUS   = 4'd2;
  localparam logic [3:0] ADDR_SCRATCH  = 4'd3;
  localparam logic [3:0] ADDR_LED      = 4'd4;
  localparam logic [3:0] ADDR_ERRCNT   = 4'd5;
  localparam logic [3:0] ADDR_ID       = 4'd6;

  localparam logic [3:0] ERR_BAD_OP   = 4'd1;
  localparam logic [3:0] ERR_TIMEOUT  = 4'd2;
  localparam logic [3:0] ERR_BAD_ADDR = 4'd3;
  localparam logic [3:0] ERR_PARTIAL  = 4'd4;

  localparam int RSP_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_DATA, ST_SEND_HDR, ST_SEND_HI, ST_SEND_LO
  } state_e;

  // Every response header shares the {nibble, nibble, 8'h00} layout.
  function automatic logic [RSP_W-1:0] rsp_hdr(input logic [3:0] hi, input logic [3:0] mid);
    return {hi, mid, 8'h00};
  endfunction

  function automatic logic addr_readable(input logic [3:0] a);
    return a <= ADDR_ID;
  endfunction

  function automatic logic addr_writable(input logic [3:0] a);
    return (a == ADDR_SCRATCH) || (a == ADDR_LED) || (a == ADDR_ERRCNT);
  endfunction

endpackage

// File: rtl/ft_cmd_if.sv
// Purpose: bridge user-FIFO bundle (RX pop side + TX push side) between controller and FT245 bridge.
// Latency: n/a (wires only).
// Backpressure: RX via ui_dout_empty, TX via ui_din_full.
interface ft_cmd_if;
  logic [15:0] ui_dout;
  logic [1:0]  ui_dout_be;
  logic        ui_dout_empty;
  logic        ui_dout_get;
  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic        ui_din_full;

  // master: the command controller; slave: the bridge FIFOs.
  modport master (
    input  ui_dout, ui_dout_be, ui_dout_empty, ui_din_full,
    output ui_dout_get, ui_din, ui_din_be, ui_din_valid
  );
  modport slave (
    output ui_dout, ui_dout_be, ui_dout_empty, ui_din_full,
    input  ui_dout_get, ui_din, ui_din_be, ui_din_valid
  );
endinterface

// File: rtl/ft_cmd_regfile.sv
// Purpose: register map read mux, writable scratch/LED registers and saturating error counter.
// Latency: reads combinational; writes and err_count updates visible the cycle after the strobe.
// Backpressure: none; strobes are single-cycle and always accepted.
// Ports: rd_addr/rd_data read port, wr_en/wr_addr/wr_data write port, err_inc count strobe,
//        telemetry inputs, led_ctrl output.
module ft_cmd_regfile
  import ft_cmd_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h5052_4F54
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        err_inc,
  input  logic [31:0] total_packets,
  input  logic [31:0] mismatch_packets,
  input  logic        link_ok,
  output logic [3:0]  led_ctrl
);

  logic [15:0] scratch_q, scratch_d;
  logic [3:0]  led_q, led_d;
  logic [15:0] err_q, err_d;

  always_comb begin
    scratch_d = scratch_q;
    led_d     = led_q;
    err_d     = err_q;
    if (wr_en) begin
      case (wr_addr)
        ADDR_SCRATCH: scratch_d = wr_data;
        ADDR_LED:     led_d     = wr_data[3:0];
        ADDR_ERRCNT:  err_d     = 16'h0000;  // any data clears
        default:      ;
      endcase
    end
    if (err_inc && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scratch_q <= '0;
      led_q     <= '0;
      err_q     <= '0;
    end else begin
      scratch_q <= scratch_d;
      led_q     <= led_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (rd_addr)
      ADDR_TOTAL:    rd_data = total_packets;
      ADDR_MISMATCH: rd_data = mismatch_packets;
      ADDR_STATUS:   rd_data = {31'h0, link_ok};
      ADDR_SCRATCH:  rd_data = {16'h0, scratch_q};
      ADDR_LED:      rd_data = {28'h0, led_q};
      ADDR_ERRCNT:   rd_data = {16'h0, err_q};
      ADDR_ID:       rd_data = ID_VALUE;
      default:       rd_data = 32'h0;
    endcase
  end

  assign led_ctrl = led_q;

endmodule

// File: rtl/ft_cmd_ctrl.sv
// Purpose: decode host command words from the bridge RX FIFO, access the register map, fire pulses, serialise responses.
// Latency: response word valid the cycle after the command (or WRITE data) pop; READ hi/lo follow one per TX transfer.
// Backpressure: TX words held while ui_din_full; no RX pop while a response is pending.
// Ports: clk/rst_n, ui (bridge FIFO bundle, master side), telemetry inputs, pulse and LED outputs.
module ft_cmd_ctrl
  import ft_cmd_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000,
  parameter logic [31:0] ID_VALUE       = 32'h5052_4F54
) (
  input  logic        clk,
  input  logic        rst_n,
  ft_cmd_if.master    ui,
  input  logic [31:0] total_packets,
  input  logic [31:0] mismatch_packets,
  input  logic        link_ok,
  output logic        reset_counters,
  output logic        gt_soft_reset_req,
  output logic [3:0]  led_ctrl
);

  state_e      state_q, state_d;
  logic [15:0] din_q, din_d;
  logic        valid_q, valid_d;
  logic [31:0] snap_q, snap_d;
  logic [3:0]  cmd_addr_q, cmd_addr_d;
  logic        read_rsp_q, read_rsp_d;
  logic [31:0] timer_q, timer_d;
  logic        rst_cnt_q, rst_cnt_d;
  logic        gt_rst_q, gt_rst_d;

  logic        get_c;
  logic        wr_en;
  logic        err_inc;
  logic [31:0] rd_data;
  logic        emit;
  logic [15:0] emit_word;
  logic        emit_err;

  logic [3:0] rx_op, rx_addr;
  assign rx_op   = ui.ui_dout[15:12];
  assign rx_addr = ui.ui_dout[11:8];

  ft_cmd_regfile #(.ID_VALUE(ID_VALUE)) u_regfile (
    .clk              (clk),
    .rst_n            (rst_n),
    .rd_addr          (rx_addr),
    .rd_data          (rd_data),
    .wr_en            (wr_en),
    .wr_addr          (cmd_addr_q),
    .wr_data          (ui.ui_dout),
    .err_inc          (err_inc),
    .total_packets    (total_packets),
    .mismatch_packets (mismatch_packets),
    .link_ok          (link_ok),
    .led_ctrl         (led_ctrl)
  );

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    valid_d    = valid_q;
    snap_d     = snap_q;
    cmd_addr_d = cmd_addr_q;
    read_rsp_d = read_rsp_q;
    timer_d    = timer_q;
    rst_cnt_d  = 1'b0;
    gt_rst_d   = 1'b0;
    get_c      = 1'b0;
    wr_en      = 1'b0;
    emit       = 1'b0;
    emit_word  = 16'h0000;
    emit_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!ui.ui_dout_empty) begin
          get_c      = 1'b1;
          read_rsp_d = 1'b0;
          if (ui.ui_dout_be != 2'b11) begin
            emit = 1'b1; emit_err = 1'b1; emit_word = rsp_hdr(OP_ERR, ERR_PARTIAL);
          end else begin
            case (rx_op)
              OP_NOP: ;
              OP_READ: begin
                emit = 1'b1;
                if (addr_readable(rx_addr)) begin
                  emit_word  = rsp_hdr(OP_READ, rx_addr);
                  snap_d     = rd_data;  // hi/lo both come from this capture
                  read_rsp_d = 1'b1;
                end else begin
                  emit_err  = 1'b1;
                  emit_word = rsp_hdr(OP_ERR, ERR_BAD_ADDR);
                end
              end
              OP_WRITE: begin
                // Address is judged when the data word arrives so a bad
                // address still consumes its data word.
                cmd_addr_d = rx_addr;
                timer_d    = 32'd0;
                state_d    = ST_WAIT_DATA;
              end
              OP_PULSE: begin
                rst_cnt_d = ui.ui_dout[0];
                gt_rst_d  = ui.ui_dout[1];
                emit      = 1'b1;
                emit_word = rsp_hdr(OP_PULSE, rx_addr);
              end
              default: begin
                emit = 1'b1; emit_err = 1'b1; emit_word = rsp_hdr(OP_ERR, ERR_BAD_OP);
              end
            endcase
          end
        end
      end
      ST_WAIT_DATA: begin
        // An available word is checked before the timeout so it wins on the last cycle.
        if (!ui.ui_dout_empty) begin
          get_c = 1'b1;
          emit  = 1'b1;
          if (ui.ui_dout_be != 2'b11) begin
            emit_err = 1'b1; emit_word = rsp_hdr(OP_ERR, ERR_PARTIAL);
          end else if (addr_writable(cmd_addr_q)) begin
            wr_en     = 1'b1;
            emit_word = rsp_hdr(OP_WRITE, cmd_addr_q);
          end else begin
            emit_err = 1'b1; emit_word = rsp_hdr(OP_ERR, ERR_BAD_ADDR);
          end
        end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
          emit = 1'b1; emit_err = 1'b1; emit_word = rsp_hdr(OP_ERR, ERR_TIMEOUT);
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_SEND_HDR: begin
        if (!ui.ui_din_full) begin
          if (read_rsp_q) begin
            din_d   = snap_q[31:16];
            state_d = ST_SEND_HI;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_SEND_HI: begin
        if (!ui.ui_din_full) begin
          din_d   = snap_q[15:0];
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (!ui.ui_din_full) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      din_d   = emit_word;
      valid_d = 1'b1;
      state_d = ST_SEND_HDR;
    end
  end

  assign err_inc = emit && emit_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      din_q      <= '0;
      valid_q    <= 1'b0;
      snap_q     <= '0;
      cmd_addr_q <= '0;
      read_rsp_q <= 1'b0;
      timer_q    <= '0;
      rst_cnt_q  <= 1'b0;
      gt_rst_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      valid_q    <= valid_d;
      snap_q     <= snap_d;
      cmd_addr_q <= cmd_addr_d;
      read_rsp_q <= read_rsp_d;
      timer_q    <= timer_d;
      rst_cnt_q  <= rst_cnt_d;
      gt_rst_q   <= gt_rst_d;
    end
  end

  // Pop is combinational from state; held low while reset is asserted.
  assign ui.ui_dout_get   = rst_n & get_c;
  assign ui.ui_din        = din_q;
  assign ui.ui_din_valid  = valid_q;
  assign ui.ui_din_be     = {2{valid_q}};
  assign reset_counters    = rst_cnt_q;
  assign gt_soft_reset_req = gt_rst_q;

endmodule

// File: tb/tb_ft_cmd_ctrl.sv
module tb_ft_cmd_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] total_packets;
  logic [31:0] mismatch_packets;
  logic        link_ok;
  logic        reset_counters;
  logic        gt_soft_reset_req;
  logic [3:0]  led_ctrl;

  int n_assert;
  int n_fail;

  ft_cmd_if ui();

  ft_cmd_ctrl #(.TIMEOUT_CYCLES(32'd20), .ID_VALUE(32'h5052_4F54)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ui                (ui),
    .total_packets     (total_packets),
    .mismatch_packets  (mismatch_packets),
    .link_ok           (link_ok),
    .reset_counters    (reset_counters),
    .gt_soft_reset_req (gt_soft_reset_req),
    .led_ctrl          (led_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one RX word, wait (bounded) for the pop, then empty the FIFO.
  // Returns just after the popping edge, i.e. inside cycle N+1.
  task automatic send_word(input logic [15:0] w, input logic [1:0] be);
    int n;
    n = 0;
    ui.ui_dout       = w;
    ui.ui_dout_be    = be;
    ui.ui_dout_empty = 1'b0;
    #1;
    while (!ui.ui_dout_get && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("rx_pop", {31'h0, ui.ui_dout_get}, 32'h1);
    @(posedge clk); #1;
    ui.ui_dout_empty = 1'b1;
  endtask

  // Check the next TX word at the next falling edge.
  task automatic expect_tx(input string tag, input logic [15:0] w);
    @(negedge clk);
    check({tag, "_vld"}, {31'h0, ui.ui_din_valid}, 32'h1);
    check({tag, "_be"},  {30'h0, ui.ui_din_be}, 32'h3);
    check(tag, {16'h0, ui.ui_din}, {16'h0, w});
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check(tag, {31'h0, ui.ui_din_valid}, 32'h0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n            = 1'b0;
    ui.ui_dout       = 16'h1000;
    ui.ui_dout_be    = 2'b11;
    ui.ui_dout_empty = 1'b0;   // word present during reset: must not be popped
    ui.ui_din_full   = 1'b0;
    total_packets    = 32'h1234_5678;
    mismatch_packets = 32'hAAAA_BBBB;
    link_ok          = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_get",   {31'h0, ui.ui_dout_get}, 32'h0);
    check("rst_din",   {16'h0, ui.ui_din}, 32'h0);
    check("rst_be",    {30'h0, ui.ui_din_be}, 32'h0);
    check("rst_vld",   {31'h0, ui.ui_din_valid}, 32'h0);
    check("rst_pulse", {30'h0, reset_counters, gt_soft_reset_req}, 32'h0);
    check("rst_led",   {28'h0, led_ctrl}, 32'h0);
    ui.ui_dout_empty = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // READ addr 0, TX never full: three consecutive words
    send_word(16'h1000, 2'b11);
    expect_tx("rd0_hdr", 16'h1000);
    expect_tx("rd0_hi",  16'h1234);
    expect_tx("rd0_lo",  16'h5678);
    expect_idle("rd0_end");

    // READ addr 1 with backpressure during SEND_HI and value change mid-response
    send_word(16'h1100, 2'b11);
    expect_tx("rd1_hdr", 16'h1100);
    expect_tx("rd1_hi",  16'hAAAA);
    ui.ui_din_full   = 1'b1;
    mismatch_packets = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rd1_hold", {15'h0, ui.ui_din_valid, ui.ui_din}, {15'h0, 1'b1, 16'hAAAA});
    end
    ui.ui_din_full = 1'b0;
    expect_tx("rd1_lo", 16'hBBBB);
    expect_idle("rd1_end");

    // NOP: no response
    send_word(16'h0000, 2'b11);
    expect_idle("nop_a");
    expect_idle("nop_b");

    // WRITE LED, then READ err_count
    send_word(16'h2400, 2'b11);
    send_word(16'h000A, 2'b11);
    expect_tx("wr4_ack", 16'h2400);
    check("wr4_led", {28'h0, led_ctrl}, 32'hA);
    expect_idle("wr4_end");
    send_word(16'h1500, 2'b11);
    expect_tx("rd5_hdr", 16'h1500);
    expect_tx("rd5_hi",  16'h0000);
    expect_tx("rd5_lo",  16'h0000);
    expect_idle("rd5_end");

    // Scratch write/readback
    send_word(16'h2300, 2'b11);
    send_word(16'hBEEF, 2'b11);
    expect_tx("wr3_ack", 16'h2300);
    expect_idle("wr3_end");
    send_word(16'h1300, 2'b11);
    expect_tx("rd3_hdr", 16'h1300);
    expect_tx("rd3_hi",  16'h0000);
    expect_tx("rd3_lo",  16'hBEEF);
    expect_idle("rd3_end");

    // PULSE both bits
    send_word(16'h3003, 2'b11);
    @(negedge clk);
    check("pls_rc",  {31'h0, reset_counters}, 32'h1);
    check("pls_gt",  {31'h0, gt_soft_reset_req}, 32'h1);
    check("pls_ack", {16'h0, ui.ui_din}, 32'h3000);
    @(negedge clk);
    check("pls_off", {30'h0, reset_counters, gt_soft_reset_req}, 32'h0);
    check("pls_end", {31'h0, ui.ui_din_valid}, 32'h0);

    // Error responses
    send_word(16'h7000, 2'b11);
    expect_tx("err_op", 16'hE100);
    expect_idle("err_op_end");
    send_word(16'h2600, 2'b11);
    send_word(16'h1234, 2'b11);
    expect_tx("err_addr", 16'hE300);
    expect_idle("err_addr_end");
    send_word(16'h1000, 2'b01);
    expect_tx("err_part", 16'hE400);
    expect_idle("err_part_end");
    send_word(16'h2300, 2'b11);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("tmo_wait", {31'h0, ui.ui_din_valid}, 32'h0);
    end
    expect_tx("err_tmo", 16'hE200);
    expect_idle("err_tmo_end");
    send_word(16'h1500, 2'b11);
    expect_tx("cnt_hdr", 16'h1500);
    expect_tx("cnt_hi",  16'h0000);
    expect_tx("cnt_lo",  16'h0004);
    expect_idle("cnt_end");

    // ID register
    send_word(16'h1600, 2'b11);
    expect_tx("id_hdr", 16'h1600);
    expect_tx("id_hi",  16'h5052);
    expect_tx("id_lo",  16'h4F54);
    expect_idle("id_end");

    // Reset during SEND_HI
    send_word(16'h1200, 2'b11);
    expect_tx("rst_rd_hdr", 16'h1200);
    expect_tx("rst_rd_hi",  16'h0000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", {31'h0, ui.ui_din_valid}, 32'h0);
    check("mid_rst_din", {16'h0, ui.ui_din}, 32'h0);
    check("mid_rst_be",  {30'h0, ui.ui_din_be}, 32'h0);
    check("mid_rst_led", {28'h0, led_ctrl}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {31'h0, ui.ui_din_valid}, 32'h0);
    end
    send_word(16'h1500, 2'b11);
    expect_tx("post_rst_hdr", 16'h1500);
    expect_tx("post_rst_hi",  16'h0000);
    expect_tx("post_rst_lo",  16'h0000);
    expect_idle("post_rst_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ft_cmd_ctrl.md
# ft_cmd_ctrl

Command/response controller between the FT245-style USB bridge user FIFOs and the telemetry path. It replaces the raw echo loop in the top level: it consumes 16-bit host command words from the bridge RX FIFO, reads or writes a small register map (telemetry counters, link status, LED control, scratch, error counter, ID), and issues control pulses (counter reset, GT soft reset). Responses are serialised back into the bridge TX FIFO. Single clock domain; all telemetry inputs are already synchronised to `clk`.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, 32'd100_000: max idle cycles waiting for a WRITE data word before abort.
- `ID_VALUE`, 32'h5052_4F54: constant returned at register address 6.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ui_dout`  in  16  RX FIFO word (first-word-fall-through).
- `ui_dout_be`  in  2  RX byte enables.
- `ui_dout_empty`  in  1  RX FIFO empty.
- `ui_dout_get`  out  1  pop RX word this cycle.
- `ui_din`  out  16  TX word.
- `ui_din_be`  out  2  TX byte enables; always 2'b11 when valid.
- `ui_din_valid`  out  1  TX word valid.
- `ui_din_full`  in  1  TX FIFO full.
- `total_packets`  in  32  telemetry packet count.
- `mismatch_packets`  in  32  telemetry mismatch count.
- `link_ok`  in  1  link count okay.
- `reset_counters`  out  1  one-cycle pulse to telemetry checker.
- `gt_soft_reset_req`  out  1  one-cycle pulse to GT subsystem.
- `led_ctrl`  out  4  host-writable LED bits.

## Operation

- Command word: [15:12] opcode, [11:8] addr, [7:0] arg.
- Opcodes: 0x0 NOP (no response); 0x1 READ; 0x2 WRITE (one data word follows); 0x3 PULSE; all others → error response code 1.
- Register map: 0 total_packets; 1 mismatch_packets; 2 status {31'h0, link_ok}; 3 scratch {16'h0, scratch[15:0]}; 4 {28'h0, led_ctrl}; 5 {16'h0, err_count}; 6 ID_VALUE. Addr > 6 → error code 3.
- Writable: 3 (scratch ← data), 4 (led_ctrl ← data[3:0]), 5 (any data clears err_count). WRITE to 0,1,2,6 → error code 3, data word still consumed.
- READ response: header {4'h1, addr, 8'h00}, then value[31:16], then value[15:0]. The 32-bit value is snapshotted on the cycle the command is popped; hi/lo are always coherent.
- WRITE/PULSE response: ack {op, addr, 8'h00}.
- PULSE: arg[0] → `reset_counters`, arg[1] → `gt_soft_reset_req`; both may fire together; arg 0 still acks.
- Error response: {4'hE, code, 8'h00}. Codes: 1 bad opcode, 2 timeout, 3 bad addr, 4 partial word (`ui_dout_be` ≠ 2'b11). A partial word is popped, discarded and reported; in WAIT_DATA it aborts the WRITE.
- err_count: 16-bit, saturates at 0xFFFF, increments once per error response.
- FSM: IDLE (pop/decode) → SEND_HDR | WAIT_DATA; WAIT_DATA → SEND_HDR (data or timeout); SEND_HDR → SEND_HI (READ) or IDLE; SEND_HI → SEND_LO → IDLE.

## Timing

- Reset values: `ui_dout_get`=0, `ui_din`=0, `ui_din_be`=0, `ui_din_valid`=0, pulses=0, `led_ctrl`=0, scratch=0, err_count=0, state IDLE. Reset mid-response discards it; no partial resumption.
- `ui_dout_get` = (state IDLE or WAIT_DATA) && !`ui_dout_empty`; word consumed at that edge. No pop in any SEND state.
- Command popped at edge N → response word valid from cycle N+1 (registered). READ with TX never full: hdr N+1, hi N+2, lo N+3; next command popped no earlier than N+4.
- TX handshake: word transfers at edge where `ui_din_valid` && !`ui_din_full`; data/valid held stable while full.
- Pulses: exactly one cycle, asserted cycle N+1 after PULSE popped at N, independent of TX backpressure.
- Register writes take effect at N+1 (edge after data word popped).
- Timeout: counter cleared on entry to WAIT_DATA; a word available on the final cycle wins over timeout.

## Structure

- Package `ft_cmd_pkg`: opcode constants, register address constants, error codes, state encoding, response header widths.
- One sub-module `ft_cmd_regfile`: register map read mux, writable registers, saturating err_count; FSM, snapshot and TX mux stay in `ft_cmd_ctrl`.

## Test plan

- READ addr 0 with total_packets=32'h1234_5678, TX never full → 16'h1000, 16'h1234, 16'h5678 on three consecutive cycles.
- READ addr 1 with `ui_din_full` high 5 cycles during SEND_HI; change mismatch_packets mid-response → words held, hi/lo from snapshot.
- WRITE addr 4 then data 16'h000A → ack 16'h2400, `led_ctrl`=4'hA; READ addr 5 → 0.
- PULSE arg 8'h03 → both pulses high exactly one cycle, ack 16'h3000.
- Opcode 0x7, WRITE addr 6, partial-be word, WRITE with no data for TIMEOUT_CYCLES → 16'hE100, 16'hE300, 16'hE400, 16'hE200; err_count=4.
- Assert `rst_n` low during SEND_HI → all outputs to reset values immediately; no further TX words.
